// File: rtl/imem_bus_responder_pkg.sv
// Shared types and bus constants for the instruction-memory bus responder.
//   BUS_BEAT_BYTES / BUS_BEAT_W : data beat size in bytes / bits (64-bit bus)
//   BEAT_OFF_W                  : byte-offset bits within one beat
//   state_e                     : responder FSM states
//   req_t                       : captured request record
package imem_bus_responder_pkg;

   localparam int unsigned BUS_BEAT_BYTES = 8;
   localparam int unsigned BUS_BEAT_W     = BUS_BEAT_BYTES * 8;
   localparam int unsigned BEAT_OFF_W     = 3;
   localparam int unsigned ADDR_W         = 64;
   localparam int unsigned LAT_W          = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]         addr;
      logic                      write;
      logic [BUS_BEAT_W-1:0]     wdata;
      logic [BUS_BEAT_BYTES-1:0] wstrb;
   } req_t;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide backing store, organised as one 8-bit lane per byte of a beat.
// Lane k at beat index i holds memory byte i*8+k, so a beat reads out
// little-endian with no byte swizzling.
//   CLK        : clock (write port only; storage is never reset)
//   rd_idx_i   : beat index for the combinational read port
//   rd_data_o  : 64-bit beat at rd_idx_i
//   wr_en_i    : write enable
//   wr_idx_i   : beat index for the write
//   wr_data_i  : 64-bit write data
//   wr_strb_i  : per-byte write enables
module imem_byte_array
   import imem_bus_responder_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic                                         CLK,
   input  logic [$clog2(MEM_BYTES)-BEAT_OFF_W-1:0]      rd_idx_i,
   output logic [BUS_BEAT_W-1:0]                        rd_data_o,
   input  logic                                         wr_en_i,
   input  logic [$clog2(MEM_BYTES)-BEAT_OFF_W-1:0]      wr_idx_i,
   input  logic [BUS_BEAT_W-1:0]                        wr_data_i,
   input  logic [BUS_BEAT_BYTES-1:0]                    wr_strb_i
);

   localparam int unsigned DEPTH = MEM_BYTES / BUS_BEAT_BYTES;

   for (genvar k = 0; k < BUS_BEAT_BYTES; k++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      // Strobed byte write; contents survive reset
      always_ff @(posedge CLK) begin
         if (wr_en_i && wr_strb_i[k]) begin
            lane_q[wr_idx_i] <= wr_data_i[8*k +: 8];
         end
      end

      assign rd_data_o[8*k +: 8] = lane_q[rd_idx_i];
   end

endmodule

// File: rtl/imem_bus_responder.sv
// Memory-side responder on the instruction-memory bus. Accepts one request
// at a time (line-fill read or single-beat strobed write), waits LATENCY
// idle cycles, then returns a burst of LINE_BEATS beats (read) or a single
// zero ack beat (write) with valid/ready handshake and a last flag.
//   CLK, RESET  : clock, synchronous active-high reset
//   req_*       : request channel (valid/ready, write, addr, wdata, wstrb)
//   resp_*      : response channel (valid/ready, data, last)
module imem_bus_responder
   import imem_bus_responder_pkg::*;
#(
   parameter int unsigned MEM_BYTES  = 1024,
   parameter int unsigned BEAT_BYTES = 8,
   parameter int unsigned LINE_BEATS = 4,
   parameter int unsigned LATENCY    = 3
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [BUS_BEAT_W-1:0]     req_wdata,
   input  logic [BUS_BEAT_BYTES-1:0] req_wstrb,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [BUS_BEAT_W-1:0]     resp_data,
   output logic                      resp_last
);

   localparam int unsigned AW    = $clog2(MEM_BYTES);
   localparam int unsigned IDX_W = AW - BEAT_OFF_W;
   localparam int unsigned BCW   = $clog2(LINE_BEATS) + 1;

   // Elaboration-time parameter sanity
   if (BEAT_BYTES != BUS_BEAT_BYTES) begin : g_bad_beat
      $error("imem_bus_responder: BEAT_BYTES must be %0d", BUS_BEAT_BYTES);
   end
   if ((LINE_BEATS < 1) || (LINE_BEATS > 16) || ((LINE_BEATS & (LINE_BEATS - 1)) != 0)) begin : g_bad_line
      $error("imem_bus_responder: LINE_BEATS must be a power of two in 1..16");
   end
   if (LATENCY > 15) begin : g_bad_lat
      $error("imem_bus_responder: LATENCY must be 0..15");
   end
   if ((MEM_BYTES & (MEM_BYTES - 1)) != 0 || MEM_BYTES < LINE_BEATS * BUS_BEAT_BYTES) begin : g_bad_mem
      $error("imem_bus_responder: MEM_BYTES must be a power of two holding at least one line");
   end

   state_e                 state_q;
   req_t                   req_q;
   logic                   req_ready_q;
   logic                   resp_valid_q;
   logic                   resp_last_q;
   logic [BUS_BEAT_W-1:0]  resp_data_q;
   logic [BCW-1:0]         beat_q;
   logic [BCW-1:0]         beat_d;
   logic [LAT_W-1:0]       lat_q;

   req_t                   cur_req_c;
   logic                   accept_c;
   logic                   first_issue_c;
   logic                   beat_hs_c;
   logic                   wr_en_c;
   logic                   next_last_c;
   logic [BCW-1:0]         issue_beat_c;
   logic [IDX_W-1:0]       line_idx_c;
   logic [IDX_W-1:0]       rd_idx_c;
   logic [IDX_W-1:0]       wr_idx_c;
   logic [BUS_BEAT_W-1:0]  rd_data_c;
   logic                   unused_addr_bits;

   // Request/beat selection feeding the array and the response registers.
   // In IDLE the live bus request is used so LATENCY=0 can issue beat 0
   // (or commit a write) on the acceptance edge itself.
   always_comb begin
      cur_req_c = req_q;
      if (state_q == IDLE) begin
         cur_req_c.addr  = req_addr;
         cur_req_c.write = req_write;
         cur_req_c.wdata = req_wdata;
         cur_req_c.wstrb = req_wstrb;
      end

      accept_c      = (state_q == IDLE) && req_ready_q && req_valid;
      first_issue_c = (accept_c && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (lat_q <= LAT_W'(1)));
      beat_hs_c     = (state_q == RESP) && resp_valid_q && resp_ready;

      beat_d       = beat_q + BCW'(1);
      issue_beat_c = (state_q == RESP) ? beat_d : '0;
      next_last_c  = (issue_beat_c == BCW'(LINE_BEATS - 1));

      // Line base drops the in-line beat bits; upper address bits alias
      line_idx_c = cur_req_c.addr[AW-1:BEAT_OFF_W] & ~IDX_W'(LINE_BEATS - 1);
      rd_idx_c   = line_idx_c | IDX_W'(issue_beat_c);
      wr_idx_c   = cur_req_c.addr[AW-1:BEAT_OFF_W];

      // Write commits on the edge entering RESP; a reset on that edge drops it
      wr_en_c = first_issue_c && cur_req_c.write && !RESET;
   end

   assign unused_addr_bits = ^{cur_req_c.addr[ADDR_W-1:AW], cur_req_c.addr[BEAT_OFF_W-1:0]};

   imem_byte_array #(
      .MEM_BYTES (MEM_BYTES)
   ) u_array (
      .CLK       (CLK),
      .rd_idx_i  (rd_idx_c),
      .rd_data_o (rd_data_c),
      .wr_en_i   (wr_en_c),
      .wr_idx_i  (wr_idx_c),
      .wr_data_i (cur_req_c.wdata),
      .wr_strb_i (cur_req_c.wstrb)
   );

   // Request/latency/response FSM with registered handshake outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         req_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         resp_data_q  <= '0;
         beat_q       <= '0;
         lat_q        <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept_c) begin
                  req_q       <= cur_req_c;
                  req_ready_q <= 1'b0;
                  lat_q       <= LAT_W'(LATENCY);
                  state_q     <= (LATENCY == 0) ? RESP : WAIT;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            WAIT: begin
               lat_q <= lat_q - LAT_W'(1);
               if (first_issue_c) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (beat_hs_c) begin
                  if (resp_last_q) begin
                     state_q      <= IDLE;
                     resp_valid_q <= 1'b0;
                     resp_last_q  <= 1'b0;
                     resp_data_q  <= '0;
                     beat_q       <= '0;
                     req_ready_q  <= 1'b1;
                  end else begin
                     beat_q      <= beat_d;
                     resp_data_q <= rd_data_c;
                     resp_last_q <= next_last_c;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         // Beat 0 of a read, or the single write ack
         if (first_issue_c) begin
            resp_valid_q <= 1'b1;
            beat_q       <= '0;
            resp_data_q  <= cur_req_c.write ? '0 : rd_data_c;
            resp_last_q  <= cur_req_c.write || next_last_c;
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_last  = resp_last_q;

   // A stalled beat must hold until accepted
   a_stall_stable : assert property (@(posedge CLK) disable iff (RESET)
      (resp_valid_q && !resp_ready) |=> (resp_valid_q && $stable(resp_data_q) && $stable(resp_last_q)));

   // Never accept a new request while a response is outstanding
   a_one_outstanding : assert property (@(posedge CLK) !(req_ready_q && resp_valid_q));

endmodule

// File: tb/tb_imem_bus_responder.sv
// Directed testbench for imem_bus_responder: a LATENCY=3 instance for the
// main scenarios and a LATENCY=0 instance for the zero-latency timing.
module tb_imem_bus_responder;

   localparam logic [63:0] INSN   = 64'h0000_0013_00A0_8093;
   localparam logic [63:0] BEEF   = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] OLD30  = 64'hA5A5_5A5A_C3C3_3C3C;
   localparam logic [63:0] NEW30  = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D0     = 64'h1122_3344_5566_7788;
   localparam logic [63:0] LOW32  = 64'h0000_0000_FFFF_FFFF;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_last;
   logic [63:0] resp_data;

   logic        req_valid0, req_ready0, req_write0;
   logic [63:0] req_addr0, req_wdata0;
   logic [7:0]  req_wstrb0;
   logic        resp_valid0, resp_ready0, resp_last0;
   logic [63:0] resp_data0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   imem_bus_responder #(.MEM_BYTES(1024), .BEAT_BYTES(8), .LINE_BEATS(4), .LATENCY(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_last(resp_last)
   );

   imem_bus_responder #(.MEM_BYTES(1024), .BEAT_BYTES(8), .LINE_BEATS(4), .LATENCY(0)) dut0 (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_data(resp_data0), .resp_last(resp_last0)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present a request and hold it until accepted; returns in the cycle after acceptance
   task automatic send_req(input logic wr, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      bit done = 1'b0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
      for (int i = 0; i < 20 && !done; i++) begin
         if (req_ready) done = 1'b1;
         step();
      end
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL req_accept addr=%h: req_ready=0 for 20 cycles, required 1", a);
      end
   endtask

   // Wait for a beat, capture it, and complete its handshake
   task automatic get_beat(output logic [63:0] d, output logic l);
      bit got = 1'b0;
      d = '0; l = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         if (resp_valid) begin
            got = 1'b1; d = resp_data; l = resp_last;
         end
         step();
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL resp_beat_timeout: resp_valid=0 for 40 cycles, required 1");
      end
   endtask

   task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [63:0] ack_d, output logic ack_l);
      send_req(1'b1, a, d, s);
      get_beat(ack_d, ack_l);
   endtask

   task automatic do_read(input logic [63:0] a, output logic [3:0][63:0] d, output logic [3:0] l);
      logic [63:0] bd;
      logic        bl;
      send_req(1'b0, a, '0, '0);
      for (int i = 0; i < 4; i++) begin
         get_beat(bd, bl);
         d[i] = bd;
         l[i] = bl;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      n_checks++; if (resp_data !== 64'h0) begin n_fail++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
      n_checks++; if (resp_last !== 1'b0) begin n_fail++; $display("FAIL rst_resp_last got=%b exp=0", resp_last); end
      RESET = 1'b0;
      step();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
      n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready0 got=%b exp=1", req_ready0); end
   endtask

   // Known contents for lines 0 and 1
   task automatic init_mem();
      logic [63:0] ad;
      logic        al;
      for (int i = 0; i < 8; i++) begin
         do_write(64'(i * 8), (i == 6) ? OLD30 : 64'h0, 8'hFF, ad, al);
      end
   endtask

   task automatic test_write_then_read();
      logic [63:0]       ad;
      logic              al;
      logic [3:0][63:0]  d;
      logic [3:0]        l;
      do_write(64'h10, INSN, 8'hFF, ad, al);
      n_checks++; if (ad !== 64'h0) begin n_fail++; $display("FAIL wr_ack_data got=%h exp=0", ad); end
      n_checks++; if (al !== 1'b1) begin n_fail++; $display("FAIL wr_ack_last got=%b exp=1", al); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after_ack got=%b exp=1", req_ready); end
      do_read(64'h0, d, l);
      n_checks++; if (d[2] !== INSN) begin n_fail++; $display("FAIL rd_beat2 got=%h exp=%h", d[2], INSN); end
      n_checks++; if (d[0] !== 64'h0) begin n_fail++; $display("FAIL rd_beat0 got=%h exp=0", d[0]); end
      n_checks++; if (d[3] !== 64'h0) begin n_fail++; $display("FAIL rd_beat3 got=%h exp=0", d[3]); end
      n_checks++; if (l !== 4'b1000) begin n_fail++; $display("FAIL rd_last_flags got=%b exp=1000", l); end
   endtask

   task automatic test_latency();
      logic [63:0] ad, bd;
      logic        al, bl;
      do_write(64'h08, BEEF, 8'hFF, ad, al);
      send_req(1'b0, 64'h0, '0, '0);
      // Now in cycle T+1
      for (int k = 1; k <= 3; k++) begin
         n_checks++;
         if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat3_idle_T+%0d got=%b exp=0", k, resp_valid); end
         step();
      end
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL lat3_first_T+4 got=%b exp=1", resp_valid); end
      for (int i = 0; i < 4; i++) begin
         get_beat(bd, bl);
         if (i == 1) begin
            n_checks++; if (bd !== BEEF) begin n_fail++; $display("FAIL lat3_beat1 got=%h exp=%h", bd, BEEF); end
         end
      end

      // Zero-latency instance: write ack and read beat 0 both at T+1
      resp_ready0 = 1'b1;
      req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 64'h20; req_wdata0 = D0; req_wstrb0 = 8'hFF;
      n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL lat0_ready got=%b exp=1", req_ready0); end
      step();
      req_valid0 = 1'b0; req_write0 = 1'b0;
      n_checks++; if (resp_valid0 !== 1'b1) begin n_fail++; $display("FAIL lat0_wr_valid_T+1 got=%b exp=1", resp_valid0); end
      n_checks++; if (resp_last0 !== 1'b1 || resp_data0 !== 64'h0) begin
         n_fail++; $display("FAIL lat0_wr_ack got=last %b data %h exp=last 1 data 0", resp_last0, resp_data0);
      end
      step();
      n_checks++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
         n_fail++; $display("FAIL lat0_wr_done got=valid %b ready %b exp=valid 0 ready 1", resp_valid0, req_ready0);
      end
      req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 64'h20;
      step();
      req_valid0 = 1'b0; req_addr0 = '0;
      n_checks++; if (resp_valid0 !== 1'b1 || resp_data0 !== D0) begin
         n_fail++; $display("FAIL lat0_rd_T+1 got=valid %b data %h exp=valid 1 data %h", resp_valid0, resp_data0, D0);
      end
      n_checks++; if (resp_last0 !== 1'b0) begin n_fail++; $display("FAIL lat0_rd_last0 got=%b exp=0", resp_last0); end
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL lat0_rd_done got=%b exp=1", req_ready0); end
   endtask

   task automatic test_backpressure();
      logic [63:0] bd;
      logic        bl;
      send_req(1'b0, 64'h0, '0, '0);
      get_beat(bd, bl);
      n_checks++; if (bd !== 64'h0) begin n_fail++; $display("FAIL bp_beat0 got=%h exp=0", bd); end
      resp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (resp_valid !== 1'b1 || resp_data !== BEEF || resp_last !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d got=v%b d%h l%b r%b exp=v1 d%h l0 r0", k, resp_valid, resp_data, resp_last, req_ready, BEEF);
         end
         step();
      end
      get_beat(bd, bl);
      n_checks++; if (bd !== BEEF || bl !== 1'b0) begin n_fail++; $display("FAIL bp_beat1 got=%h/%b exp=%h/0", bd, bl, BEEF); end
      get_beat(bd, bl);
      n_checks++; if (bd !== INSN || bl !== 1'b0) begin n_fail++; $display("FAIL bp_beat2 got=%h/%b exp=%h/0", bd, bl, INSN); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_last got=%b exp=0", req_ready); end
      get_beat(bd, bl);
      n_checks++; if (bd !== 64'h0 || bl !== 1'b1) begin n_fail++; $display("FAIL bp_beat3 got=%h/%b exp=0/1", bd, bl); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_last got=%b exp=1", req_ready); end
   endtask

   task automatic test_strobe_alias();
      logic [63:0]      ad;
      logic             al;
      logic [3:0][63:0] d;
      logic [3:0][63:0] exp_line;
      logic [3:0]       l;
      exp_line[0] = 64'h0; exp_line[1] = LOW32; exp_line[2] = INSN; exp_line[3] = 64'h0;
      do_write(64'h08, 64'h0, 8'hFF, ad, al);
      do_write(64'h408, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, ad, al);
      do_read(64'h0, d, l);
      n_checks++; if (d[1] !== LOW32) begin n_fail++; $display("FAIL strb_alias_beat1 got=%h exp=%h", d[1], LOW32); end
      n_checks++; if (d[2] !== INSN) begin n_fail++; $display("FAIL strb_beat2_intact got=%h exp=%h", d[2], INSN); end
      do_read(64'h1F, d, l);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (d[i] !== exp_line[i]) begin n_fail++; $display("FAIL unaligned_beat%0d got=%h exp=%h", i, d[i], exp_line[i]); end
      end
      n_checks++; if (l !== 4'b1000) begin n_fail++; $display("FAIL unaligned_last got=%b exp=1000", l); end
   endtask

   task automatic test_reset_mid_burst();
      logic [63:0]      bd;
      logic             bl;
      logic [3:0][63:0] d;
      logic [3:0]       l;
      send_req(1'b0, 64'h0, '0, '0);
      get_beat(bd, bl);
      get_beat(bd, bl);
      n_checks++; if (resp_valid !== 1'b1 || resp_data !== INSN) begin
         n_fail++; $display("FAIL mid_beat2_present got=v%b d%h exp=v1 d%h", resp_valid, resp_data, INSN);
      end
      RESET = 1'b1;
      step();
      n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_abort got=v%b r%b exp=v0 r0", resp_valid, req_ready);
      end
      n_checks++; if (resp_data !== 64'h0 || resp_last !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_outputs got=d%h l%b exp=d0 l0", resp_data, resp_last);
      end
      RESET = 1'b0;
      step();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
      do_read(64'h0, d, l);
      n_checks++; if (d[1] !== LOW32 || d[2] !== INSN) begin
         n_fail++; $display("FAIL mid_rst_reread got=%h %h exp=%h %h", d[1], d[2], LOW32, INSN);
      end
      n_checks++; if (l !== 4'b1000) begin n_fail++; $display("FAIL mid_rst_last got=%b exp=1000", l); end
   endtask

   task automatic test_reset_write_wait();
      logic [3:0][63:0] d;
      logic [3:0]       l;
      send_req(1'b1, 64'h30, NEW30, 8'hFF);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wwait_rst_valid got=%b exp=0", resp_valid); end
      step();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wwait_rst_ready got=%b exp=1", req_ready); end
      do_read(64'h20, d, l);
      n_checks++; if (d[2] !== OLD30) begin n_fail++; $display("FAIL wwait_discarded got=%h exp=%h", d[2], OLD30); end
   endtask

   initial begin
      RESET = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 1'b1;
      req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
      resp_ready0 = 1'b1;

      test_reset();
      init_mem();
      test_write_then_read();
      test_latency();
      test_backpressure();
      test_strobe_alias();
      test_reset_mid_burst();
      test_reset_write_wait();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
